// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg: shared types and constants for the RV32I memory subsystem   |
// | rev 1.0  initial unified program/data memory support                 |
// +----------------------------------------------------------------------+
package cpu_pkg;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_D    = 2'd2
    } resp_owner_t;

    localparam int WORD_ADDR_SHIFT = 2;

endpackage
`default_nettype wire

// File: rtl/unified_mem_arbiter_starve_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | starve_counter: saturating up-counter with synchronous clear          |
// | rev 1.0  initial                                                     |
// +----------------------------------------------------------------------+
module starve_counter #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] c_LIMIT = WIDTH'(LIMIT);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != c_LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | unified_mem_arbiter: fetch/load-store sharing of one memory port     |
// | rev 1.0  data priority with bounded fetch starvation                 |
// +----------------------------------------------------------------------+
module unified_mem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W       = 30,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       if_wait_cnt
);

    localparam int                  c_STREAK_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(STARVE_LIMIT);

    logic [c_STREAK_W-1:0] w_streak;
    logic                  w_fetch_wins;
    resp_owner_t           r_resp_owner;
    resp_owner_t           w_resp_owner_nxt;

    // Fetch only beats a pending data request once the streak has saturated.
    assign w_fetch_wins = if_req && (!d_req || (w_streak == c_STREAK_MAX));
    assign if_gnt       = rst_n && w_fetch_wins;
    assign d_gnt        = rst_n && d_req && !w_fetch_wins;

    assign mem_en    = if_gnt || d_gnt;
    assign mem_we    = d_gnt && d_we;
    assign mem_addr  = d_gnt ? d_addr : if_addr;
    assign mem_wdata = d_wdata;

    starve_counter #(
        .WIDTH (c_STREAK_W),
        .LIMIT (STARVE_LIMIT)
    ) u_streak (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!if_req || if_gnt),
        .inc   (d_gnt),
        .cnt   (w_streak)
    );

    starve_counter #(
        .WIDTH (16),
        .LIMIT (16'hFFFF)
    ) u_if_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (if_req && !if_gnt),
        .cnt   (if_wait_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_resp_owner <= RESP_NONE;
        end else begin
            r_resp_owner <= w_resp_owner_nxt;
        end
    end

    // Stores complete at grant, so only reads claim the next-cycle response.
    always_comb begin
        w_resp_owner_nxt = RESP_NONE;
        if (if_gnt) begin
            w_resp_owner_nxt = RESP_IF;
        end else if (d_gnt && !d_we) begin
            w_resp_owner_nxt = RESP_D;
        end
    end

    assign if_rvalid = (r_resp_owner == RESP_IF);
    assign d_rvalid  = (r_resp_owner == RESP_D);
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_unified_mem_arbiter: directed bench with a cycle-level model      |
// | rev 1.0  initial                                                     |
// +----------------------------------------------------------------------+
module tb_unified_mem_arbiter;

    localparam int c_LIMIT = 4;
    localparam int c_NONE  = 0;
    localparam int c_IF    = 1;
    localparam int c_D     = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [29:0] if_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [29:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [29:0] mem_addr;
    logic [15:0] if_wait_cnt;

    // Second instance: starvation limit far beyond the run, for counter saturation.
    logic        rst2_n = 1'b0;
    logic        if_gnt2, if_rvalid2, d_gnt2, d_rvalid2, mem_en2, mem_we2;
    logic [31:0] if_rdata2, d_rdata2, mem_wdata2;
    logic [29:0] mem_addr2;
    logic [15:0] if_wait_cnt2;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] bmem [64];
    logic [31:0] sh   [64];

    int          m_streak = 0;
    int          m_wait = 0;
    int          m_prev = 0;
    logic [31:0] m_rdata = '0;
    int          eg = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_W(30), .DATA_W(32), .STARVE_LIMIT(c_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .if_wait_cnt(if_wait_cnt)
    );

    unified_mem_arbiter #(.ADDR_W(30), .DATA_W(32), .STARVE_LIMIT(200000)) dut_sat (
        .clk(clk), .rst_n(rst2_n),
        .if_req(1'b1), .if_addr(30'd0), .if_gnt(if_gnt2),
        .if_rvalid(if_rvalid2), .if_rdata(if_rdata2),
        .d_req(1'b1), .d_we(1'b0), .d_addr(30'd1), .d_wdata(32'd0),
        .d_gnt(d_gnt2), .d_rvalid(d_rvalid2), .d_rdata(d_rdata2),
        .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .mem_rdata(32'd0), .if_wait_cnt(if_wait_cnt2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word memory behind the DUT, write-first single port.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) bmem[mem_addr[5:0]] <= mem_wdata;
            else        mem_rdata <= bmem[mem_addr[5:0]];
        end
    end

    // Compare against the model mid-cycle, when inputs and outputs are settled.
    always @(negedge clk) begin
        if (!rst_n)                                     eg = c_NONE;
        else if (if_req && (!d_req || m_streak >= c_LIMIT)) eg = c_IF;
        else if (d_req)                                 eg = c_D;
        else                                            eg = c_NONE;
        chk("if_gnt", 64'(if_gnt), 64'(eg == c_IF));
        chk("d_gnt", 64'(d_gnt), 64'(eg == c_D));
        chk("mem_en", 64'(mem_en), 64'(eg != c_NONE));
        if (eg != c_NONE) begin
            chk("mem_we", 64'(mem_we), 64'(eg == c_D && d_we));
            chk("mem_addr", 64'(mem_addr), 64'(eg == c_D ? d_addr : if_addr));
            if (eg == c_D && d_we) chk("mem_wdata", 64'(mem_wdata), 64'(d_wdata));
        end
        chk("if_rvalid", 64'(if_rvalid), 64'(m_prev == c_IF));
        chk("d_rvalid", 64'(d_rvalid), 64'(m_prev == c_D));
        if (m_prev == c_IF) chk("if_rdata", 64'(if_rdata), 64'(m_rdata));
        if (m_prev == c_D)  chk("d_rdata", 64'(d_rdata), 64'(m_rdata));
        chk("if_wait_cnt", 64'(if_wait_cnt), 64'(m_wait));
    end

    // Model state advances at the edge, using the reset level seen there.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_streak = 0;
            m_wait   = 0;
            m_prev   = c_NONE;
        end else begin
            if (if_req && eg != c_IF && m_wait < 65535) m_wait++;
            if (!if_req || eg == c_IF)                  m_streak = 0;
            else if (eg == c_D && m_streak < c_LIMIT)   m_streak++;
            m_prev = c_NONE;
            if (eg == c_IF) begin
                m_prev  = c_IF;
                m_rdata = sh[if_addr[5:0]];
            end else if (eg == c_D) begin
                if (d_we) sh[d_addr[5:0]] = d_wdata;
                else begin
                    m_prev  = c_D;
                    m_rdata = sh[d_addr[5:0]];
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic ir, input logic [29:0] ia,
                       input logic dr, input logic dw, input logic [29:0] da,
                       input logic [31:0] dwd);
        @(posedge clk);
        #1;
        rst_n = r; if_req = ir; if_addr = ia;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
        @(negedge clk);
    endtask

    initial begin
        logic [9:0] pat;
        logic [4:0] pat2;
        for (int i = 0; i < 64; i++) begin
            bmem[i] = 32'hA000_0000 | 32'(i);
            sh[i]   = 32'hA000_0000 | 32'(i);
        end

        // Reset held with both requesters active: no grants, no responses.
        cyc(0, 1, 0, 1, 0, 1, 0);
        cyc(0, 1, 0, 1, 0, 1, 0);
        chk("rst_if_gnt", 64'(if_gnt), 64'd0);
        chk("rst_d_gnt", 64'(d_gnt), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
        chk("rst_wait", 64'(if_wait_cnt), 64'd0);
        rst2_n = 1'b1;

        // Fetch only.
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("fo_gnt0", 64'(if_gnt), 64'd1);
        cyc(1, 1, 1, 0, 0, 0, 0);
        chk("fo_rv0", 64'({if_rvalid, if_rdata}), {31'd0, 1'b1, 32'hA000_0000});
        cyc(1, 1, 2, 0, 0, 0, 0);
        chk("fo_rv1", 64'({if_rvalid, if_rdata}), {31'd0, 1'b1, 32'hA000_0001});
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("fo_rv2", 64'({if_rvalid, if_rdata}), {31'd0, 1'b1, 32'hA000_0002});
        chk("fo_wait", 64'(if_wait_cnt), 64'd0);

        // Store then load, same address.
        cyc(1, 0, 0, 1, 1, 5, 32'hDEAD_BEEF);
        chk("st_gnt", 64'({d_gnt, mem_we}), 64'd3);
        cyc(1, 0, 0, 1, 0, 5, 0);
        chk("st_no_rvalid", 64'(d_rvalid), 64'd0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("ld_data", 64'({d_rvalid, d_rdata}), {31'd0, 1'b1, 32'hDEAD_BEEF});

        // Interleaved owners.
        cyc(1, 1, 7, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 3, 0);
        chk("il_if", 64'({if_rvalid, d_rvalid}), 64'b10);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("il_d", 64'({if_rvalid, d_rvalid}), 64'b01);
        chk("il_d_data", 64'(d_rdata), 64'h0000_0000_A000_0003);

        // Contention: data wins four times, then fetch.
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 9, 1, 0, 4, 0);
            pat[i] = if_gnt;
        end
        chk("ct_pattern", 64'(pat), 64'b10_0001_0000);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("ct_wait", 64'(if_wait_cnt), 64'd8);

        // Reset lands on the edge right after a load grant.
        cyc(1, 0, 0, 1, 0, 2, 0);
        chk("rr_gnt", 64'(d_gnt), 64'd1);
        rst_n = 1'b0;
        cyc(0, 1, 0, 1, 0, 1, 0);
        chk("rr_rvalid", 64'(d_rvalid), 64'd0);
        chk("rr_ctl", 64'({if_gnt, d_gnt, mem_en, mem_we}), 64'd0);
        cyc(0, 1, 0, 1, 0, 1, 0);
        chk("rr_ctl2", 64'({if_gnt, d_gnt, mem_en, mem_we}), 64'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 9, 1, 0, 4, 0);
            if (i == 0) chk("rr_wait0", 64'(if_wait_cnt), 64'd0);
            pat2[i] = if_gnt;
        end
        chk("rr_pattern", 64'(pat2), 64'b1_0000);
        cyc(1, 0, 0, 0, 0, 0, 0);

        // Saturation of the wait counter on the starved instance.
        repeat (65600) @(posedge clk);
        #1;
        chk("sat_wait", 64'(if_wait_cnt2), 64'hFFFF);
        chk("sat_no_if_gnt", 64'(if_gnt2), 64'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("sat_hold", 64'(if_wait_cnt2), 64'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-port synchronous word memory between the instruction-fetch requester and the load/store requester of the RV32I core. It is the first step from the split instruction/data memories to a unified program+data image. Data accesses have priority, with a bounded-starvation rule that guarantees fetch progress. Read data returns one cycle after grant, tagged to the owning requester.

## Interface
Parameters:
- ADDR_W, 30, word-address width (byte address >> 2)
- DATA_W, 32, data width
- STARVE_LIMIT, 4, max consecutive data grants while fetch waits (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  ADDR_W  fetch word address, stable while if_req
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_rvalid  out  1  fetch read data valid (registered)
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data granted this cycle (combinational)
- d_rvalid  out  1  load data valid (registered)
- d_rdata  out  DATA_W  load data
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en & !mem_we
- if_wait_cnt  out  16  saturating count of cycles with if_req & !if_gnt

## Operation
- At most one grant per cycle. Grant is driven in the same cycle as the request. The memory port is driven from the granted requester.
- Priority: d_req wins, unless streak == STARVE_LIMIT and if_req is high; in that case fetch wins.
- streak counter (0..STARVE_LIMIT):
  - Increments on a data grant while if_req is high.
  - Resets to 0 on a fetch grant, or on any cycle with if_req low.
  - Saturates at STARVE_LIMIT.
- Response tracking: register resp_owner {NONE, IF, D}. Set to IF on a fetch grant, D on a load grant, NONE otherwise (stores and idle cycles).
- Next-cycle outputs from resp_owner:
  - if_rvalid = (resp_owner == IF); d_rvalid = (resp_owner == D).
  - if_rdata = d_rdata = mem_rdata; consumers qualify with rvalid.
- Stores produce no rvalid. d_gnt is the store's completion.
- Requester rule: after a grant, a requester may present a new request in the very next cycle (back-to-back). Responses stay in order because read latency is fixed at 1.
- if_wait_cnt increments every cycle with if_req & !if_gnt and saturates at 16'hFFFF.
- Reset (rst_n == 0 at a clk edge):
  - streak = 0, resp_owner = NONE, if_wait_cnt = 0.
  - While rst_n is low, if_gnt, d_gnt, mem_en and mem_we are forced to 0.
  - A response in flight is dropped: rvalid is 0 in the cycle after the reset edge.

## Timing
- Grant latency: 0 cycles when uncontested.
- Read data latency: 1 cycle after grant.
- Store: committed at the clock edge of the grant cycle.
- Worst-case fetch wait while data requests saturate: STARVE_LIMIT cycles.
- Reset values: if_rvalid = 0, d_rvalid = 0, if_wait_cnt = 0. Grant and mem_* controls are 0 during reset. mem_addr and mem_wdata are don't-care when mem_en = 0.
- Simultaneous requests: the priority rule above. A fetch grant in cycle N and a data grant in cycle N+1 yield if_rvalid at N+1 and d_rvalid at N+2.
- Same-address store then load on consecutive cycles: the load returns the new data (memory write-first at the edge).
- Combinational path: req → gnt → mem_* only. No path from mem_rdata to any grant.

## Structure
- Shared package (cpu_pkg):
  - typedef enum logic [1:0] resp_owner_t {RESP_NONE, RESP_IF, RESP_D}.
  - Constant WORD_ADDR_SHIFT = 2.
- One sub-module: starve_counter (saturating up-counter with clear; parameterised width and limit). It is instantiated for streak. if_wait_cnt uses the same module with limit 16'hFFFF.
- The existing memory module connects unchanged on the mem_* side.

## Test plan
- Fetch only: if_req = 1 with addresses 0, 1, 2 on consecutive cycles → if_gnt = 1 each cycle, if_rvalid = 1 one cycle later with memory words 0, 1, 2; if_wait_cnt stays 0.
- Contention: if_req and d_req both held high continuously, STARVE_LIMIT = 4 → grant pattern D, D, D, D, IF, D, D, D, D, IF…; if_wait_cnt increments by 4 per period.
- Store then load: d_we = 1, addr 5, wdata 32'hDEADBEEF; next cycle d_we = 0, addr 5 → d_rvalid one cycle later with d_rdata = 32'hDEADBEEF; no d_rvalid for the store.
- Interleaved owners: fetch grant at cycle 10, load grant at cycle 11 → if_rvalid only at 11, d_rvalid only at 12, never both high together.
- Reset mid-read: load granted at cycle N, rst_n = 0 at edge N+1 → d_rvalid = 0 at N+1; grants and mem_en = 0 while reset is held; streak and if_wait_cnt read 0 after release.
- Saturation: if_req held with d_req constantly high and STARVE_LIMIT forced large, run 70000 cycles → if_wait_cnt = 16'hFFFF and holds that value.
